// File: rtl/rtc_bus_sequencer.sv
// Bus-cycle generator for the RTC multiplexed AD bus: one address phase, a CS-high gap,
// then one read or write data phase. All bus and handshake outputs are registered.
module rtc_bus_sequencer #(
    parameter int unsigned T_SETUP  = 2,
    parameter int unsigned T_STROBE = 5,
    parameter int unsigned T_HOLD   = 2,
    parameter int unsigned T_GAP    = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       rw,
    input  logic [7:0] bus_in,
    output logic       ad_n,
    output logic       cs_n,
    output logic       rd_n,
    output logic       wr_n,
    output logic       drive_addr,
    output logic       drive_data,
    output logic       fetch,
    output logic [7:0] rd_data,
    output logic       busy,
    output logic       done
);

    typedef enum logic [3:0] {
        IDLE, A_SETUP, A_STROBE, A_HOLD, GAP, D_SETUP, D_STROBE, D_HOLD, DONE
    } state_t;

    localparam logic [7:0] LD_SETUP  = 8'(T_SETUP - 1);
    localparam logic [7:0] LD_STROBE = 8'(T_STROBE - 1);
    localparam logic [7:0] LD_HOLD   = 8'(T_HOLD - 1);
    localparam logic [7:0] LD_GAP    = 8'(T_GAP - 1);

    state_t     state, state_nx;
    logic [7:0] cnt, cnt_nx;
    logic       dir, dir_nx;
    logic       armed, armed_nx;
    logic       a_ph, d_ph, d_strobe;

    // Each timed state leaves when its down-counter reaches zero and loads the next dwell.
    always_comb begin
        state_nx = state;
        cnt_nx   = (cnt == 8'd0) ? 8'd0 : cnt - 8'd1;
        dir_nx   = dir;
        armed_nx = armed;
        unique case (state)
            IDLE: begin
                if (!start) armed_nx = 1'b1;
                if (start && armed) begin
                    state_nx = A_SETUP;
                    cnt_nx   = LD_SETUP;
                    dir_nx   = rw;
                    armed_nx = 1'b0;
                end
            end
            A_SETUP:  if (cnt == 8'd0) begin state_nx = A_STROBE; cnt_nx = LD_STROBE; end
            A_STROBE: if (cnt == 8'd0) begin state_nx = A_HOLD;   cnt_nx = LD_HOLD;   end
            A_HOLD:   if (cnt == 8'd0) begin state_nx = GAP;      cnt_nx = LD_GAP;    end
            GAP:      if (cnt == 8'd0) begin state_nx = D_SETUP;  cnt_nx = LD_SETUP;  end
            D_SETUP:  if (cnt == 8'd0) begin state_nx = D_STROBE; cnt_nx = LD_STROBE; end
            D_STROBE: if (cnt == 8'd0) begin state_nx = D_HOLD;   cnt_nx = LD_HOLD;   end
            D_HOLD:   if (cnt == 8'd0) begin state_nx = DONE;     cnt_nx = 8'd0;      end
            DONE:     state_nx = IDLE;
            default:  state_nx = IDLE;
        endcase
    end

    // Outputs are decoded from the state being entered so they change on the entry edge.
    always_comb begin
        a_ph     = (state_nx == A_SETUP) || (state_nx == A_STROBE) || (state_nx == A_HOLD);
        d_ph     = (state_nx == D_SETUP) || (state_nx == D_STROBE) || (state_nx == D_HOLD);
        d_strobe = (state_nx == D_STROBE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            cnt        <= 8'd0;
            dir        <= 1'b0;
            armed      <= 1'b1;
            ad_n       <= 1'b1;
            cs_n       <= 1'b1;
            rd_n       <= 1'b1;
            wr_n       <= 1'b1;
            drive_addr <= 1'b0;
            drive_data <= 1'b0;
            fetch      <= 1'b0;
            rd_data    <= 8'h00;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_nx;
            cnt        <= cnt_nx;
            dir        <= dir_nx;
            armed      <= armed_nx;
            ad_n       <= !a_ph;
            cs_n       <= !(a_ph || d_ph);
            rd_n       <= !(d_strobe && dir_nx);
            wr_n       <= !((state_nx == A_STROBE) || (d_strobe && !dir_nx));
            drive_addr <= a_ph;
            drive_data <= d_ph && !dir_nx;
            fetch      <= d_strobe && dir_nx && (cnt_nx == 8'd0);
            busy       <= (state_nx != IDLE);
            done       <= (state_nx == DONE);
            // fetch marks the final D_STROBE cycle, so this edge is the one leaving it.
            if (fetch) rd_data <= bus_in;
        end
    end

endmodule

// File: tb/tb_rtc_bus_sequencer.sv
// Directed bench for rtc_bus_sequencer: default-timing instance plus an all-ones-timing
// instance, checked cycle by cycle against hand-derived phase windows.
module tb_rtc_bus_sequencer;

    logic       clk;
    logic       rst;
    logic       start, start1;
    logic       rw;
    logic [7:0] bus_in;

    logic       ad_n0, cs_n0, rd_n0, wr_n0, drive_addr0, drive_data0, fetch0, busy0, done0;
    logic [7:0] rd_data0;
    logic       ad_n1, cs_n1, rd_n1, wr_n1, drive_addr1, drive_data1, fetch1, busy1, done1;
    logic [7:0] rd_data1;

    int checks;
    int failures;
    logic [7:0] exp_rd0, exp_rd1;

    localparam logic [8:0] IDLE_VEC = 9'b1111_00000;

    rtc_bus_sequencer dut0 (
        .clk(clk), .rst(rst), .start(start), .rw(rw), .bus_in(bus_in),
        .ad_n(ad_n0), .cs_n(cs_n0), .rd_n(rd_n0), .wr_n(wr_n0),
        .drive_addr(drive_addr0), .drive_data(drive_data0), .fetch(fetch0),
        .rd_data(rd_data0), .busy(busy0), .done(done0)
    );

    rtc_bus_sequencer #(.T_SETUP(1), .T_STROBE(1), .T_HOLD(1), .T_GAP(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .rw(rw), .bus_in(bus_in),
        .ad_n(ad_n1), .cs_n(cs_n1), .rd_n(rd_n1), .wr_n(wr_n1),
        .drive_addr(drive_addr1), .drive_data(drive_data1), .fetch(fetch1),
        .rd_data(rd_data1), .busy(busy1), .done(done1)
    );

    logic [8:0] v0, v1;
    assign v0 = {ad_n0, cs_n0, rd_n0, wr_n0, drive_addr0, drive_data0, fetch0, busy0, done0};
    assign v1 = {ad_n1, cs_n1, rd_n1, wr_n1, drive_addr1, drive_data1, fetch1, busy1, done1};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected output vector for cycle j after the accept edge, from the phase windows.
    function automatic logic [8:0] exp_vec(input int j, input bit rd, input int a_end,
                                           input int s1, input int s1e, input int d_s,
                                           input int d_e, input int s2, input int s2e,
                                           input int done_j);
        bit in_a, in_d, in_s1, in_s2;
        in_a  = (j <= a_end);
        in_d  = (j >= d_s) && (j <= d_e);
        in_s1 = (j >= s1) && (j <= s1e);
        in_s2 = (j >= s2) && (j <= s2e);
        return {!in_a, !(in_a || in_d), !(rd && in_s2), !(in_s1 || (!rd && in_s2)),
                in_a, (!rd && in_d), (rd && j == s2e), (j <= done_j), (j == done_j)};
    endfunction

    task automatic run_xfer(input string tag, input bit use1, input bit rd, input bit hold,
                            input bit perturb, input logic [7:0] byte_v,
                            input int a_end, input int s1, input int s1e, input int d_s,
                            input int d_e, input int s2, input int s2e, input int done_j);
        rw = rd;
        if (use1) start1 = 1'b1;
        else start = 1'b1;
        tick();
        if (!hold) begin
            start  = 1'b0;
            start1 = 1'b0;
        end
        for (int j = 0; j <= done_j + 2; j++) begin
            bus_in = (j >= s2 && j <= s2e) ? byte_v : 8'h55;
            if (perturb) begin
                if (j == 3 || j == 10) rw = ~rw;
                if (j == 5) start = 1'b1;
                if (j == 6) start = 1'b0;
            end
            if (rd && j == s2e + 1) begin
                if (use1) exp_rd1 = byte_v;
                else exp_rd0 = byte_v;
            end
            if (use1) begin
                check($sformatf("%s vec j=%0d", tag, j), 32'(v1),
                      32'(exp_vec(j, rd, a_end, s1, s1e, d_s, d_e, s2, s2e, done_j)));
                check($sformatf("%s rd_data j=%0d", tag, j), 32'(rd_data1), 32'(exp_rd1));
            end else begin
                check($sformatf("%s vec j=%0d", tag, j), 32'(v0),
                      32'(exp_vec(j, rd, a_end, s1, s1e, d_s, d_e, s2, s2e, done_j)));
                check($sformatf("%s rd_data j=%0d", tag, j), 32'(rd_data0), 32'(exp_rd0));
            end
            tick();
        end
    endtask

    initial begin
        int activity;
        checks   = 0;
        failures = 0;
        exp_rd0  = 8'h00;
        exp_rd1  = 8'h00;
        rst      = 1'b0;
        start    = 1'b0;
        start1   = 1'b0;
        rw       = 1'b0;
        bus_in   = 8'h00;

        // Reset state
        repeat (3) tick();
        check("reset vec0", 32'(v0), 32'(IDLE_VEC));
        check("reset vec1", 32'(v1), 32'(IDLE_VEC));
        check("reset rd_data0", 32'(rd_data0), 32'h00);
        #2 rst = 1'b1;
        repeat (2) tick();
        check("idle vec0", 32'(v0), 32'(IDLE_VEC));

        // Default-timing write, then read capturing 3A at the end of D_STROBE
        run_xfer("wr_dflt", 1'b0, 1'b0, 1'b0, 1'b0, 8'hA5, 8, 2, 6, 13, 21, 15, 19, 22);
        run_xfer("rd_dflt", 1'b0, 1'b1, 1'b0, 1'b0, 8'h3A, 8, 2, 6, 13, 21, 15, 19, 22);

        // start held high for 100 cycles: one transfer only, then re-arm after a low
        run_xfer("hold", 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8, 2, 6, 13, 21, 15, 19, 22);
        activity = 0;
        repeat (75) begin
            if (busy0 || done0) activity++;
            tick();
        end
        check("hold no second xfer", 32'(activity), 32'd0);
        start = 1'b0;
        tick();
        run_xfer("rearm_wr", 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8, 2, 6, 13, 21, 15, 19, 22);

        // start/rw wiggled mid-transfer: read direction latched at accept must persist
        run_xfer("perturb_rd", 1'b0, 1'b1, 1'b0, 1'b1, 8'hC5, 8, 2, 6, 13, 21, 15, 19, 22);

        // Asynchronous reset in the middle of D_STROBE of a read
        rw    = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (16) tick();
        check("pre_rst rd_n strobe", 32'(rd_n0), 32'd0);
        #2 rst = 1'b0;
        #1;
        check("async rst vec0", 32'(v0), 32'(IDLE_VEC));
        check("async rst rd_data0", 32'(rd_data0), 32'h00);
        exp_rd0 = 8'h00;
        exp_rd1 = 8'h00;
        start   = 1'b1;
        tick();
        check("in rst busy0", 32'(busy0), 32'd0);
        #3 rst = 1'b1;
        run_xfer("post_rst_rd", 1'b0, 1'b1, 1'b0, 1'b0, 8'h3A, 8, 2, 6, 13, 21, 15, 19, 22);

        // All timing parameters = 1
        run_xfer("p1_wr", 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 2, 1, 1, 4, 6, 5, 5, 7);
        run_xfer("p1_rd", 1'b1, 1'b1, 1'b0, 1'b0, 8'h81, 2, 1, 1, 4, 6, 5, 5, 7);
        check("p1 final rd_data1", 32'(rd_data1), 32'h81);
        check("dflt final rd_data0", 32'(rd_data0), 32'h3A);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
